jpeg_idct_sched: RTL and testbench

- Block-level scheduler in front of the IDCT pipeline (coefficient RAM -> row IDCT -> transpose -> column IDCT).
- Admits 8x8 coefficient blocks from the entropy/dequant stage and caps the number of blocks in flight to MAX_INFLIGHT, which protects the block-ID FIFO (depth 8) from overflow.
- Counts block completions from the IDCT output stream, drains the pipeline at image end and reports image completion.

---
 rtl/jpeg_idct_sched.sv | 167 ++++++++++++++++
 tb/tb_jpeg_idct_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_idct_sched.sv
// Block admission/credit scheduler ahead of the IDCT pipe; optional drain watchdog via JPEG_IDCT_SCHED_TIMEOUT_EN.
// Latency: admission gating is combinational (0 cycles); completion/counter/status outputs register 1 cycle.
// Backpressure: up_accept_o follows idct_accept_i only while admitted; new blocks stall at MAX_INFLIGHT.
module jpeg_idct_sched #(
    parameter int MAX_INFLIGHT   = 8,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             img_start_i,
    input  logic             img_end_i,
    input  logic             up_valid_i,
    input  logic             up_eob_i,
    output logic             up_accept_o,
    output logic             idct_valid_o,
    input  logic             idct_accept_i,
    input  logic             out_valid_i,
    input  logic [5:0]       out_idx_i,
    output logic [3:0]       inflight_o,
    output logic             blk_done_o,
    output logic [CNT_W-1:0] blk_count_o,
    output logic             busy_o,
    output logic             img_done_o,
    output logic             err_overflow_o,
    output logic             err_timeout_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

    state_t           state_q, state_d;
    logic             in_blk_q;
    logic [3:0]       inflight_q;
    logic [CNT_W-1:0] blk_count_q;
    logic             blk_done_q;
    logic             busy_q;
    logic             err_ovf_q;
    logic             admit;
    logic             beat;
    logic             reserve;
    logic             comp;
    logic             timeout;
    logic             img_done;

    // An open block always continues; only a fresh block consumes a credit.
    assign admit = ((state_q == RUN) && (in_blk_q || (inflight_q < MAX_CNT))) ||
                   ((state_q == DRAIN) && in_blk_q);

    assign idct_valid_o = up_valid_i & admit;
    assign up_accept_o  = idct_accept_i & admit;

    assign beat    = up_valid_i & up_accept_o;
    assign reserve = beat & ~in_blk_q;
    assign comp    = out_valid_i && (out_idx_i == 6'd63);

`ifdef JPEG_IDCT_SCHED_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_q;
    logic            err_to_q;

    assign timeout = (state_q == DRAIN) && !comp && !img_start_i &&
                     (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wd_q     <= '0;
            err_to_q <= 1'b0;
        end else begin
            if (state_q != DRAIN || comp || img_start_i)
                wd_q <= '0;
            else
                wd_q <= wd_q + 1'b1;

            if (img_start_i)
                err_to_q <= 1'b0;
            else if (timeout)
                err_to_q <= 1'b1;
        end
    end

    assign err_timeout_o = err_to_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign err_timeout_o      = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        img_done = 1'b0;
        case (state_q)
            IDLE:  state_d = IDLE;
            RUN:   if (img_end_i) state_d = DRAIN;
            DRAIN: if (timeout || (!in_blk_q && inflight_q == 4'd0)) state_d = DONE;
            DONE: begin
                img_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Start-of-image restarts from any state and swallows a pending done pulse.
        if (img_start_i) begin
            state_d  = RUN;
            img_done = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN) || (state_d == DRAIN);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            in_blk_q    <= 1'b0;
            inflight_q  <= 4'd0;
            blk_count_q <= '0;
            blk_done_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else if (img_start_i) begin
            in_blk_q    <= 1'b0;
            inflight_q  <= 4'd0;
            blk_count_q <= '0;
            blk_done_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            blk_done_q <= comp;
            if (comp)
                blk_count_q <= blk_count_q + 1'b1;

            if (timeout) begin
                in_blk_q   <= 1'b0;
                inflight_q <= 4'd0;
            end else begin
                if (beat)
                    in_blk_q <= ~up_eob_i;
                // Reserve and completion on the same edge cancel out.
                if (reserve && !comp)
                    inflight_q <= inflight_q + 4'd1;
                else if (comp && !reserve) begin
                    if (inflight_q == 4'd0)
                        err_ovf_q <= 1'b1;
                    else
                        inflight_q <= inflight_q - 4'd1;
                end
            end
        end
    end

    assign inflight_o     = inflight_q;
    assign blk_done_o     = blk_done_q;
    assign blk_count_o    = blk_count_q;
    assign busy_o         = busy_q;
    assign img_done_o     = img_done;
    assign err_overflow_o = err_ovf_q;

endmodule

// File: tb/tb_jpeg_idct_sched.sv
// Directed bench: two scheduler instances (credit limit 8 and 1) muxed by sel onto one stimulus set.
module tb_jpeg_idct_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel;
    logic       img_start, img_end, up_valid, up_eob, idct_accept, out_valid;
    logic [5:0] out_idx;

    logic        s0_start, s0_end, s0_valid, s0_eob, s0_acc, s0_ovld;
    logic        s1_start, s1_end, s1_valid, s1_eob, s1_acc, s1_ovld;
    assign s0_start = img_start & ~sel;   assign s1_start = img_start & sel;
    assign s0_end   = img_end & ~sel;     assign s1_end   = img_end & sel;
    assign s0_valid = up_valid & ~sel;    assign s1_valid = up_valid & sel;
    assign s0_eob   = up_eob & ~sel;      assign s1_eob   = up_eob & sel;
    assign s0_acc   = idct_accept & ~sel; assign s1_acc   = idct_accept & sel;
    assign s0_ovld  = out_valid & ~sel;   assign s1_ovld  = out_valid & sel;

    logic        up_accept0, idct_valid0, blk_done0, busy0, img_done0, err_ovf0, err_to0;
    logic        up_accept1, idct_valid1, blk_done1, busy1, img_done1, err_ovf1, err_to1;
    logic [3:0]  inflight0, inflight1;
    logic [15:0] blk_count0, blk_count1;

    jpeg_idct_sched #(.MAX_INFLIGHT(8), .CNT_W(16), .TIMEOUT_CYCLES(16)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .img_start_i(s0_start), .img_end_i(s0_end),
        .up_valid_i(s0_valid), .up_eob_i(s0_eob), .up_accept_o(up_accept0),
        .idct_valid_o(idct_valid0), .idct_accept_i(s0_acc), .out_valid_i(s0_ovld),
        .out_idx_i(out_idx), .inflight_o(inflight0), .blk_done_o(blk_done0),
        .blk_count_o(blk_count0), .busy_o(busy0), .img_done_o(img_done0),
        .err_overflow_o(err_ovf0), .err_timeout_o(err_to0)
    );

    jpeg_idct_sched #(.MAX_INFLIGHT(1), .CNT_W(16), .TIMEOUT_CYCLES(16)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .img_start_i(s1_start), .img_end_i(s1_end),
        .up_valid_i(s1_valid), .up_eob_i(s1_eob), .up_accept_o(up_accept1),
        .idct_valid_o(idct_valid1), .idct_accept_i(s1_acc), .out_valid_i(s1_ovld),
        .out_idx_i(out_idx), .inflight_o(inflight1), .blk_done_o(blk_done1),
        .blk_count_o(blk_count1), .busy_o(busy1), .img_done_o(img_done1),
        .err_overflow_o(err_ovf1), .err_timeout_o(err_to1)
    );

    logic        up_accept, idct_valid, blk_done, busy, img_done, err_ovf, err_to;
    logic [3:0]  inflight;
    logic [15:0] blk_count;
    assign up_accept  = sel ? up_accept1  : up_accept0;
    assign idct_valid = sel ? idct_valid1 : idct_valid0;
    assign blk_done   = sel ? blk_done1   : blk_done0;
    assign busy       = sel ? busy1       : busy0;
    assign img_done   = sel ? img_done1   : img_done0;
    assign err_ovf    = sel ? err_ovf1    : err_ovf0;
    assign err_to     = sel ? err_to1     : err_to0;
    assign inflight   = sel ? inflight1   : inflight0;
    assign blk_count  = sel ? blk_count1  : blk_count0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input string tag);
        int rej;
        rej = 0;
        for (int b = 0; b < 64; b++) begin
            up_valid = 1'b1;
            up_eob   = (b == 63);
            #1;
            if (!up_accept) rej++;
            tick();
        end
        up_valid = 1'b0;
        up_eob   = 1'b0;
        chk(tag, rej, 0);
    endtask

    task automatic complete();
        out_valid = 1'b1;
        out_idx   = 6'd63;
        tick();
        out_valid = 1'b0;
        out_idx   = 6'd0;
    endtask

    task automatic start_img();
        img_start = 1'b1;
        tick();
        img_start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        int acc;
        int done_cnt;
        int n;
        sel = 1'b0; rst = 1'b0; img_start = 1'b0; img_end = 1'b0;
        up_valid = 1'b1; up_eob = 1'b0; idct_accept = 1'b1;
        out_valid = 1'b0; out_idx = 6'd0;

        // Reset values, with upstream already requesting.
        #12;
        chk("rst_inflight", inflight, 0);
        chk("rst_blk_count", blk_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_up_accept", up_accept, 0);
        chk("rst_idct_valid", idct_valid, 0);
        chk("rst_img_done", img_done, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_err_to", err_to, 0);
        up_valid = 1'b0;
        rst = 1'b1;
        tick();

        // Credit limit at 8 blocks.
        start_img();
        chk("start_busy", busy, 1);
        for (int i = 0; i < 8; i++) send_block($sformatf("credit_blk%0d_stall", i));
        chk("credit_inflight_full", inflight, 8);
        up_valid = 1'b1;
        up_eob   = 1'b0;
        #1;
        chk("credit_accept_blocked", up_accept, 0);
        chk("credit_valid_blocked", idct_valid, 0);
        repeat (5) tick();
        chk("credit_inflight_hold", inflight, 8);
        complete();
        chk("credit_blk_done", blk_done, 1);
        chk("credit_inflight_dec", inflight, 7);
        chk("credit_blk_count", blk_count, 1);
        #1;
        chk("credit_accept_reopen", up_accept, 1);
        up_valid = 1'b0;
        send_block("credit_blk8_stall");
        chk("credit_inflight_refull", inflight, 8);
        chk("credit_blk_done_clear", blk_done, 0);
        out_valid = 1'b1;
        out_idx   = 6'd62;
        tick();
        out_valid = 1'b0;
        out_idx   = 6'd0;
        chk("idx62_no_count", blk_count, 1);

        // Reserve and completion on the same edge.
        start_img();
        chk("flush_inflight", inflight, 0);
        chk("flush_blk_count", blk_count, 0);
        for (int i = 0; i < 4; i++) send_block($sformatf("sim_blk%0d_stall", i));
        chk("sim_inflight_pre", inflight, 4);
        up_valid  = 1'b1;
        up_eob    = 1'b0;
        out_valid = 1'b1;
        out_idx   = 6'd63;
        tick();
        out_valid = 1'b0;
        out_idx   = 6'd0;
        chk("sim_inflight_same", inflight, 4);
        chk("sim_blk_done", blk_done, 1);
        chk("sim_blk_count", blk_count, 1);
        for (int b = 1; b < 64; b++) begin
            up_eob = (b == 63);
            tick();
        end
        up_valid = 1'b0;
        up_eob   = 1'b0;
        chk("sim_inflight_post", inflight, 4);

        // Drain after image end.
        start_img();
        for (int i = 0; i < 3; i++) send_block($sformatf("drain_blk%0d_stall", i));
        img_end = 1'b1;
        tick();
        img_end = 1'b0;
        chk("drain_busy", busy, 1);
        up_valid = 1'b1;
        #1;
        chk("drain_no_admit", up_accept, 0);
        up_valid = 1'b0;
        repeat (3) tick();
        chk("drain_busy_wait", busy, 1);
        chk("drain_inflight_wait", inflight, 3);
        for (int i = 0; i < 3; i++) begin
            complete();
            tick();
        end
        chk("drain_inflight_zero", inflight, 0);
        chk("drain_blk_count", blk_count, 3);
        done_cnt = 0;
        repeat (6) begin
            if (img_done) done_cnt++;
            tick();
        end
        chk("drain_done_once", done_cnt, 1);
        chk("drain_blk_count_end", blk_count, 3);
        chk("drain_busy_end", busy, 0);
        chk("drain_err_to", err_to, 0);
        up_valid = 1'b1;
        #1;
        chk("idle_no_admit", up_accept, 0);
        up_valid = 1'b0;
        img_end = 1'b1;
        tick();
        img_end = 1'b0;
        tick();
        chk("idle_end_ignored", busy, 0);

        // Overflow error, flush, asynchronous reset mid-block.
        complete();
        chk("ovf_set", err_ovf, 1);
        chk("ovf_inflight", inflight, 0);
        chk("ovf_blk_count", blk_count, 4);
        start_img();
        chk("flush_err_ovf", err_ovf, 0);
        chk("flush_blk_count2", blk_count, 0);
        chk("flush_busy", busy, 1);
        complete();
        chk("ovf_again", err_ovf, 1);
        up_valid = 1'b1;
        up_eob   = 1'b0;
        repeat (10) tick();
        chk("midblk_inflight", inflight, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_inflight", inflight, 0);
        chk("arst_blk_count", blk_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_up_accept", up_accept, 0);
        chk("arst_idct_valid", idct_valid, 0);
        chk("arst_err_ovf", err_ovf, 0);
        up_valid = 1'b0;
        rst = 1'b1;
        tick();

        // Single-credit instance: next block waits for the completion, then streams unstalled.
        sel = 1'b1;
        #1;
        start_img();
        send_block("mid_blk1_stall");
        chk("mid_inflight1", inflight, 1);
        up_valid = 1'b1;
        up_eob   = 1'b0;
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (up_accept || idct_valid) acc++;
            tick();
        end
        chk("mid_hold_no_start", acc, 0);
        chk("mid_inflight_hold", inflight, 1);
        complete();
        chk("mid_inflight_free", inflight, 0);
        chk("mid_blk_done", blk_done, 1);
        up_valid = 1'b0;
        send_block("mid_blk2_stall");
        chk("mid_inflight_blk2", inflight, 1);
        chk("mid_blk_count", blk_count, 1);
        sel = 1'b0;
        #1;

`ifdef JPEG_IDCT_SCHED_TIMEOUT_EN
        // Drain watchdog with no completions.
        start_img();
        send_block("to_blk0_stall");
        send_block("to_blk1_stall");
        img_end = 1'b1;
        tick();
        img_end = 1'b0;
        n = 0;
        while (!err_to && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 16);
        chk("to_img_done", img_done, 1);
        chk("to_inflight", inflight, 0);
        tick();
        chk("to_done_single", img_done, 0);
        chk("to_sticky", err_to, 1);
`else
        n = 0;
        chk("to_disabled", err_to, n);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
